// File: rtl/wb_regfile.sv
// wb_regfile: Y86-64 writeback register file (15x64 regs, 2 comb read ports with optional W bypass, sticky halt status, saturating retire count)
module wb_regfile #(
  parameter logic [63:0] RSP_INIT = 64'd0,
  parameter logic        BYPASS   = 1'b1,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       W_stat,
  input  logic [3:0]       W_icode,
  input  logic [63:0]      W_valE,
  input  logic [63:0]      W_valM,
  input  logic [3:0]       W_dstE,
  input  logic [3:0]       W_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [63:0]      d_rvalA,
  output logic [63:0]      d_rvalB,
  output logic             halted,
  output logic [1:0]       prog_stat,
  output logic [CNT_W-1:0] retired
);
  logic [63:0] r [15];
  logic we, byp;
  assign we  = W_stat == 2'd0 && !halted;
  assign byp = BYPASS && we;
  for (genvar g = 0; g < 15; g++) begin : g_reg
    always_ff @(posedge clk)
      if (rst) r[g] <= g == 4 ? RSP_INIT : 64'd0;
      else if (we && W_dstM == 4'(g)) r[g] <= W_valM;
      else if (we && W_dstE == 4'(g)) r[g] <= W_valE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      halted    <= 1'b0;
      prog_stat <= 2'd0;
      retired   <= '0;
    end else begin
      if (!halted && W_stat != 2'd0) begin
        halted    <= 1'b1;
        prog_stat <= W_stat;
      end
      if (we && W_icode != 4'h1 && retired != {CNT_W{1'b1}}) retired <= retired + CNT_W'(1);
    end
  end
  assign d_rvalA = d_srcA == 4'hF ? 64'd0 :
                   byp && d_srcA == W_dstM ? W_valM :
                   byp && d_srcA == W_dstE ? W_valE : r[d_srcA];
  assign d_rvalB = d_srcB == 4'hF ? 64'd0 :
                   byp && d_srcB == W_dstM ? W_valM :
                   byp && d_srcB == W_dstE ? W_valE : r[d_srcB];
endmodule
